instr_fetch_mem: RTL

//  Parametrised, clocked instruction memory with valid/ready request and response channels.

---
 rtl/im_pkg.sv | 20 ++
 rtl/im_rsp_fifo.sv | 58 +++++
 rtl/instr_fetch_mem.sv | 108 ++++++++++
 3 files changed

// File: rtl/im_pkg.sv
// Shared constants, response payload type and helpers for the instruction fetch memory.
package im_pkg;

  localparam logic [31:0] IM_NOP     = 32'h0000_0013;
  localparam int          IM_LAT_MAX = 4;
  localparam int          IM_RSP_W   = 33;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } im_rsp_t;

  function automatic int im_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/im_rsp_fifo.sv
// First-word-fall-through response queue, DEPTH x IM_RSP_W (DEPTH a power of 2, >= 2).
// Pointers carry one extra wrap bit so full and empty differ only in the MSB.
module im_rsp_fifo
  import im_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [IM_RSP_W-1:0]        push_data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [IM_RSP_W-1:0]        data_o,
  output logic [im_clog2(DEPTH):0]   count_o
);

  localparam int AW = im_clog2(DEPTH);

  logic [IM_RSP_W-1:0] mem_q [DEPTH];
  logic [AW:0]         wr_q, rd_q, wr_d, rd_d;
  logic                empty, full;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign valid_o = !empty;
  // Idle output is forced to zero so the payload never shows stale storage.
  assign data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i && !full)  wr_d = wr_q + (AW+1)'(1);
      if (pop_i  && !empty) rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full && !flush_i) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Pipelined, credit-limited byte-addressed instruction memory (big-endian words).
// Define IM_ERR_CHECK_EN to flag misaligned/out-of-range fetches with rsp_err and an IM_NOP payload.
module instr_fetch_mem
  import im_pkg::*;
#(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic              rsp_err
);

  localparam int MW = im_clog2(MEM_BYTES);
  localparam int CW = im_clog2(RSP_DEPTH);

  logic [7:0]    InstrMem [0:MEM_BYTES-1];

  logic          run_q;
  logic          acc, pop, push;
  logic [ADDR_W:0] ba;
  im_rsp_t       rd_rsp, push_rsp, q_rsp;
  logic [CW:0]   q_cnt, inflight;

  // Holds req_ready low through reset and for the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign req_ready = run_q && !flush && ((int'(inflight) + int'(q_cnt)) < RSP_DEPTH);
  assign acc       = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    rd_rsp = '0;
    ba     = '0;
    for (int k = 0; k < 4; k++) begin
      ba           = {1'b0, req_addr} + (ADDR_W+1)'(k);
      rd_rsp.instr = {rd_rsp.instr[23:0], InstrMem[MW'(ba % (ADDR_W+1)'(MEM_BYTES))]};
    end
`ifdef IM_ERR_CHECK_EN
    if (req_addr[1:0] != 2'b00 || {1'b0, req_addr} > (ADDR_W+1)'(MEM_BYTES - 4)) begin
      rd_rsp.err   = 1'b1;
      rd_rsp.instr = IM_NOP;
    end
`endif
  end

  // Stage 0 is the combinational read; LATENCY-1 register stages follow, then the queue.
  if (LATENCY == 1) begin : g_lat1
    assign push     = acc;
    assign push_rsp = rd_rsp;
    assign inflight = '0;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_pipe_q;
    im_rsp_t            dat_pipe_q [LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe_q <= '0;
      end else if (flush) begin
        vld_pipe_q <= '0;
      end else begin
        vld_pipe_q[0] <= acc;
        for (int s = 1; s < LATENCY-1; s++) vld_pipe_q[s] <= vld_pipe_q[s-1];
      end
    end

    always_ff @(posedge clk) begin
      dat_pipe_q[0] <= rd_rsp;
      for (int s = 1; s < LATENCY-1; s++) dat_pipe_q[s] <= dat_pipe_q[s-1];
    end

    always_comb begin
      inflight = '0;
      for (int s = 0; s < LATENCY-1; s++) inflight = inflight + (CW+1)'(vld_pipe_q[s]);
    end

    assign push     = vld_pipe_q[LATENCY-2];
    assign push_rsp = dat_pipe_q[LATENCY-2];
  end

  im_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (push_rsp),
    .pop_i       (pop),
    .valid_o     (rsp_valid),
    .data_o      (q_rsp),
    .count_o     (q_cnt)
  );

  assign rsp_instr = q_rsp.instr;
  assign rsp_err   = q_rsp.err;

endmodule
